sram_port_ctrl: RTL and testbench
=================================

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word address width of the SRAM 1RW port.
REQ-002 SHALL have parameter DATA_WIDTH, default 33: SRAM word width, 32 data bits plus spare bit 32.
REQ-003 SHALL have port clk, input, 1: the one clock for the block and the SRAM macro.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1: request present.
REQ-006 SHALL have port req_ready_o, output, 1: request accepted on an edge where valid and ready are both high.
REQ-007 SHALL have port req_we_i, input, 1: 1=write, 0=read.
REQ-008 SHALL have port req_be_i, input, 4: byte enables for writes.
REQ-009 SHALL have port req_addr_i, input, ADDR_WIDTH: word address.
REQ-010 SHALL have port req_wdata_i, input, 32: write data.
REQ-011 SHALL have port rsp_valid_o, output, 1: one-cycle response pulse per accepted request.
REQ-012 SHALL have port rsp_rdata_o, output, 32: read data (0 for writes).
REQ-013 SHALL have port rsp_err_o, output, 1: read parity error.
REQ-014 SHALL have ports sram_csb0_o (1), sram_web0_o (1), sram_wmask0_o (4), sram_spare_wen0_o (1), sram_addr0_o (ADDR_WIDTH) and sram_din0_o (DATA_WIDTH) as outputs, driving the SRAM port.
REQ-015 SHALL have port sram_dout0_i, input, DATA_WIDTH: SRAM read data, valid before the next posedge after the command edge.

Function
REQ-016 SHALL implement FSM states IDLE and RMW_WR.
REQ-017 SHALL drive req_ready_o = (state==IDLE) combinationally.
REQ-018 In IDLE, SRAM outputs SHALL be combinational from the request: csb0=!(valid&ready), web0=!we, addr0=addr, din0[31:0]=wdata, wmask0=be.
REQ-019 A SRAM command is sampled on the same edge as acceptance.
REQ-020 rsp_valid_o SHALL pulse for exactly one cycle, set at the edge after the edge where the final SRAM command of the request is sampled.
REQ-021 Reads and full writes SHALL therefore respond 1 edge after acceptance.
REQ-022 Throughput SHALL be 1 request per cycle for reads and full writes.
REQ-023 rsp_rdata_o SHALL be registered from sram_dout0_i[31:0] for reads and set to 0 for writes.
REQ-024 rsp_rdata_o SHALL hold its value between responses.
REQ-025 A write with be=4'h0 SHALL keep csb0 high and still produce a response.
REQ-026 Responses have no backpressure and SHALL be issued in acceptance order.
REQ-027 A read issued the cycle after a write to the same address SHALL return the new data, with no stall; the SRAM writes on negedge.
REQ-028 No request SHALL be accepted while state≠IDLE.

Reset
REQ-029 On rst the block SHALL go to IDLE with rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, sram_csb0_o=1 and sram_web0_o=1; all holding registers SHALL be cleared.
REQ-030 A rst during RMW_WR SHALL drop the pending write, issue no SRAM write and produce no response.

Configuration
REQ-031 Macro SRAM_PARITY_EN SHALL enable parity protection.
REQ-032 With SRAM_PARITY_EN, every write SHALL store parity din0[32]=^data[31:0] with spare_wen0=1 and wmask0=4'hF.
REQ-033 With SRAM_PARITY_EN, a write with be=4'hF SHALL be a single cycle.
REQ-034 With SRAM_PARITY_EN, a write with be not equal to 4'hF and not 4'h0 SHALL be read-modify-write: edge k accept, read command, capture addr/be/wdata, go to RMW_WR.
REQ-035 In RMW_WR, the block SHALL drive a write of merge(dout0[31:0], held wdata per held be) with parity, sampled at edge k+1, then return to IDLE; the response SHALL come at edge k+2.
REQ-036 With SRAM_PARITY_EN, a read response SHALL set rsp_err_o = dout0[32] ^ (^dout0[31:0]).
REQ-037 Without SRAM_PARITY_EN, spare_wen0 and din0[32] SHALL be 0, wmask0 SHALL equal be, rsp_err_o SHALL be tied 0, and RMW_WR SHALL be unreachable.

Verification
REQ-038 Write 0xDEADBEEF to addr 5 with be=F, then read addr 5 -> each response arrives 1 edge after acceptance; rdata=0xDEADBEEF, err=0.
REQ-039 Back-to-back reads of addrs 0..7, valid held high -> ready stays 1; 8 responses on consecutive cycles, in order.
REQ-040 (PARITY) addr 3 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 -> ready low 1 cycle, response at acceptance+2; readback gives 0x11BB33DD, err=0.
REQ-041 (PARITY) Force sram_dout0_i[32] inverted on a read -> rsp_err_o=1 with that response only.
REQ-042 Assert rst in the RMW_WR cycle -> no SRAM write (csb0=1); addr unchanged on readback; no rsp_valid_o.
REQ-043 Write with be=0 -> csb0 stays 1; response 1 edge later with rdata=0.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: valid/ready request front end for a 1RW SRAM macro with a one-cycle response pulse.
// Define SRAM_PARITY_EN to store word parity in bit 32 and turn partial writes into read-modify-write.
module sram_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [3:0]            req_be_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [3:0]            sram_wmask0_o,
  output logic                  sram_spare_wen0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

`ifdef SRAM_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_rmw_start;
  logic                  w_wr_none;
  logic [31:0]           w_merge;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic                  r_pend_vld;
  logic                  r_pend_rd;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_d,
                                              input logic [31:0] new_d,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    return m;
  endfunction

  function automatic logic parity32(input logic [31:0] d);
    return ^d;
  endfunction

  assign req_ready_o = (r_state == IDLE);
  assign w_accept    = req_valid_i & req_ready_o;
  assign w_wr_none   = req_we_i & (req_be_i == 4'h0);
  assign w_rmw_start = PARITY & w_accept & req_we_i & (req_be_i != 4'hF) & (req_be_i != 4'h0);
  assign w_merge     = merge_bytes(sram_dout0_i[31:0], r_wdata, r_be);

  always_comb begin
    w_state_nxt       = r_state;
    sram_csb0_o       = 1'b1;
    sram_web0_o       = 1'b1;
    sram_wmask0_o     = 4'h0;
    sram_spare_wen0_o = 1'b0;
    sram_addr0_o      = req_addr_i;
    sram_din0_o       = '0;
    case (r_state)
      IDLE: begin
        sram_csb0_o       = ~w_accept | w_wr_none;
        // A partial write under parity first reads the old word.
        sram_web0_o       = ~req_we_i | w_rmw_start;
        sram_wmask0_o     = PARITY ? 4'hF : req_be_i;
        sram_spare_wen0_o = PARITY & req_we_i;
        sram_din0_o[31:0] = req_wdata_i;
        sram_din0_o[32]   = PARITY & parity32(req_wdata_i);
        if (w_rmw_start) w_state_nxt = RMW_WR;
      end
      RMW_WR: begin
        sram_csb0_o       = 1'b0;
        sram_web0_o       = 1'b0;
        sram_wmask0_o     = 4'hF;
        sram_spare_wen0_o = PARITY;
        sram_addr0_o      = r_addr;
        sram_din0_o[31:0] = w_merge;
        sram_din0_o[32]   = PARITY & parity32(w_merge);
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // The macro must never see a command while reset is held, including a pending RMW write.
    if (rst) begin
      sram_csb0_o = 1'b1;
      sram_web0_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_rmw_start) begin
      r_addr  <= req_addr_i;
      r_be    <= req_be_i;
      r_wdata <= req_wdata_i;
    end
  end

  // Pending stage marks the edge where a request's final SRAM command was sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend_rd  <= 1'b0;
    end else begin
      r_pend_vld <= (w_accept & ~w_rmw_start) | (r_state == RMW_WR);
      r_pend_rd  <= w_accept & ~req_we_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= r_pend_vld;
      r_rsp_err   <= PARITY & r_pend_vld & r_pend_rd &
                     (sram_dout0_i[32] ^ parity32(sram_dout0_i[31:0]));
      if (r_pend_vld) r_rsp_rdata <= r_pend_rd ? sram_dout0_i[31:0] : 32'h0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: randomized and directed bench for sram_port_ctrl with an SRAM macro model
// and a word-level reference memory; honours SRAM_PARITY_EN the same way as the design.
module tb_sram_port_ctrl;
  localparam int AW = 10;
  localparam int DW = 33;
`ifdef SRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [3:0]    req_be_i = 4'h0;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          sram_csb0_o;
  logic          sram_web0_o;
  logic [3:0]    sram_wmask0_o;
  logic          sram_spare_wen0_o;
  logic [AW-1:0] sram_addr0_o;
  logic [DW-1:0] sram_din0_o;
  logic [DW-1:0] sram_dout0_i;

  sram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o), .sram_wmask0_o(sram_wmask0_o),
    .sram_spare_wen0_o(sram_spare_wen0_o), .sram_addr0_o(sram_addr0_o),
    .sram_din0_o(sram_din0_o), .sram_dout0_i(sram_dout0_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SRAM macro model: read data registered on posedge, write committed on the following negedge.
  logic [32:0] mem [1024];
  logic [32:0] dout_r = '0;
  logic        flip_nxt = 1'b0;
  logic        wr_p = 1'b0;
  logic [AW-1:0] wa;
  logic [32:0] wd;
  logic [3:0]  wm;
  logic        ws;

  assign sram_dout0_i = dout_r;

  always @(posedge clk) begin
    wr_p <= 1'b0;
    if (!sram_csb0_o) begin
      if (sram_web0_o) dout_r <= {mem[sram_addr0_o][32] ^ flip_nxt, mem[sram_addr0_o][31:0]};
      else begin
        wr_p <= 1'b1;
        wa   <= sram_addr0_o;
        wd   <= sram_din0_o;
        wm   <= sram_wmask0_o;
        ws   <= sram_spare_wen0_o;
      end
    end
  end

  always @(negedge clk) begin
    if (wr_p) begin
      for (int i = 0; i < 4; i++) if (wm[i]) mem[wa][8*i +: 8] = wd[8*i +: 8];
      if (ws) mem[wa][32] = wd[32];
    end
  end

  // Reference model: word memory plus queue of expected responses with due cycle.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [1024];
  int          cyc = 0;
  logic        rmw_pend = 1'b0;
  logic [AW-1:0] rmw_addr;
  logic [3:0]  rmw_be;
  logic [31:0] rmw_data;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      q.delete();
      rmw_pend   = 1'b0;
      last_rdata = '0;
    end else begin
      if (rmw_pend) begin
        ref_mem[rmw_addr] = apply_be(ref_mem[rmw_addr], rmw_data, rmw_be);
        rmw_pend = 1'b0;
      end
      if (req_valid_i && req_ready_o) begin
        e.cyc  = cyc + 1;
        e.data = '0;
        e.err  = 1'b0;
        if (!req_we_i) begin
          e.data = ref_mem[req_addr_i];
          e.err  = PAR & flip_nxt;
        end else if (PAR && req_be_i != 4'hF && req_be_i != 4'h0) begin
          rmw_pend = 1'b1;
          rmw_addr = req_addr_i;
          rmw_be   = req_be_i;
          rmw_data = req_wdata_i;
          e.cyc    = cyc + 2;
        end else begin
          ref_mem[req_addr_i] = apply_be(ref_mem[req_addr_i], req_wdata_i, req_be_i);
        end
        q.push_back(e);
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (rsp_valid_o) begin
        if (q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        else begin
          e = q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
          chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.data));
          chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
        end
        last_rdata = rsp_rdata_o;
        last_err   = rsp_err_o;
      end else begin
        chk("rdata_hold", 64'(rsp_rdata_o), 64'(last_rdata));
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          chk("rsp_missing", 64'(rsp_valid_o), 64'd1);
          void'(q.pop_front());
        end
      end
      chk("ready", 64'(req_ready_o), 64'(!rmw_pend));
      if (rmw_pend) begin
        chk("rmw_csb", 64'(sram_csb0_o), 64'd0);
        chk("rmw_web", 64'(sram_web0_o), 64'd0);
        chk("rmw_addr", 64'(sram_addr0_o), 64'(rmw_addr));
      end else if (req_valid_i && req_ready_o) begin
        chk("cmd_csb", 64'(sram_csb0_o), 64'(req_we_i && req_be_i == 4'h0));
        chk("cmd_addr", 64'(sram_addr0_o), 64'(req_addr_i));
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with valid still high.
  task automatic issue(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic flip);
    int t;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_be_i    = be;
    req_addr_i  = a;
    req_wdata_i = d;
    flip_nxt    = flip;
    t = 0;
    while (!req_ready_o && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready_o) chk("ready_timeout", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    flip_nxt    = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata_o), 64'd0);
    chk("rst_err", 64'(rsp_err_o), 64'd0);
    chk("rst_csb", 64'(sram_csb0_o), 64'd1);
    chk("rst_web", 64'(sram_web0_o), 64'd1);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 4'hF, 10'd5, 32'h0, 1'b0);
    idle(3);
    chk("deadbeef_rd", 64'(last_rdata), 64'h0DEADBEEF);
    chk("deadbeef_err", 64'(last_err), 64'd0);

    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", 64'(req_ready_o), 64'd1);
      issue(1'b0, 4'hF, AW'(i), 32'h0, 1'b0);
    end
    idle(3);
    chk("b2b_last", 64'(last_rdata), 64'(ref_mem[7]));

    issue(1'b1, 4'h0, 10'd9, 32'h12345678, 1'b0);
    idle(3);
    chk("be0_rdata", 64'(last_rdata), 64'd0);

    issue(1'b1, 4'hF, 10'd3, 32'h11223344, 1'b0);
    issue(1'b1, 4'b0101, 10'd3, 32'hAABBCCDD, 1'b0);
    issue(1'b0, 4'hF, 10'd3, 32'h0, 1'b0);
    idle(3);
    chk("merge_rd", 64'(last_rdata), PAR ? 64'h11BB33DD : 64'h11BB33DD);

`ifdef SRAM_PARITY_EN
    issue(1'b0, 4'hF, 10'd3, 32'h0, 1'b1);
    idle(1);
    issue(1'b0, 4'hF, 10'd3, 32'h0, 1'b0);
    idle(3);
    chk("par_err_clear", 64'(last_err), 64'd0);
`endif

    // Reset right after accepting a request must drop it entirely.
    issue(1'b1, 4'hF, 10'd7, 32'hCAFEF00D, 1'b0);
    idle(3);
    req_valid_i = 1'b1;
    req_we_i    = PAR;
    req_be_i    = 4'b0011;
    req_addr_i  = 10'd7;
    req_wdata_i = 32'h55667788;
    @(posedge clk);
    #1 rst = 1'b1;
    req_valid_i = 1'b0;
    #1;
    chk("rstmid_csb", 64'(sram_csb0_o), 64'd1);
    chk("rstmid_web", 64'(sram_web0_o), 64'd1);
    @(posedge clk);
    #1;
    chk("rstmid_rsp", 64'(rsp_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rsp2", 64'(rsp_valid_o), 64'd0);
    issue(1'b0, 4'hF, 10'd7, 32'h0, 1'b0);
    idle(3);
    chk("rstmid_keep", 64'(last_rdata), 64'hCAFEF00D);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] be;
      int sel;
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 4) == 0) idle(1);
      issue(1'($urandom), be, AW'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 7) == 0));
    end
    idle(6);
    chk("drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
